// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch front end: owns the PC, issues pair reads to a
// registered ROM, buffers returned pairs in a show-ahead FIFO for decode.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr1,
  input  logic [31:0]       rom_instr2,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [31:0]       dec_pc,
  output logic [31:0]       dec_instr1,
  output logic [31:0]       dec_instr2
);

  localparam int unsigned PC_W  = ADDR_W + 2;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [ADDR_W-1:0] LAST_WORD = '1;
  localparam logic [PC_W-1:0]   RST_PC    = {RESET_PC[PC_W-1:2], 2'b00};

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PC_W-1:0]  pc_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_d [DEPTH];
  logic [31:0]      i1_mem_q [DEPTH];
  logic [31:0]      i1_mem_d [DEPTH];
  logic [31:0]      i2_mem_q [DEPTH];
  logic [31:0]      i2_mem_d [DEPTH];

  logic             dec_valid_q, dec_valid_d;
  logic [31:0]      dec_pc_q, dec_pc_d;
  logic [31:0]      dec_instr1_q, dec_instr1_d;
  logic [31:0]      dec_instr2_q, dec_instr2_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      ret_instr2;
  logic             unused_bits;

  assign unused_bits = ^redirect_pc;
  assign rom_addr    = fetch_pc_q[PC_W-1:2];
  assign dec_valid   = dec_valid_q;
  assign dec_pc      = dec_pc_q;
  assign dec_instr1  = dec_instr1_q;
  assign dec_instr2  = dec_instr2_q;

  // Issue is gated on buffered plus in-flight pairs so a returning pair always has a slot.
  assign occupancy  = OCC_W'(count_q) + OCC_W'(inflight_q);
  assign issue      = !redirect_valid && (occupancy < OCC_W'(DEPTH));
  assign push       = inflight_q && !redirect_valid;
  assign pop        = (count_q != '0) && dec_ready && !redirect_valid;
  assign ret_instr2 = (inflight_pc_q[PC_W-1:2] == LAST_WORD) ? NOP : rom_instr2;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pc_mem_d      = pc_mem_q;
    i1_mem_d      = i1_mem_q;
    i2_mem_d      = i2_mem_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + PC_W'(8);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        pc_mem_d[wr_ptr_q] = inflight_pc_q;
        i1_mem_d[wr_ptr_q] = rom_instr1;
        i2_mem_d[wr_ptr_q] = ret_instr2;
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head registers track the post-edge FIFO head, so a fresh push to an empty FIFO shows at once.
  always_comb begin
    dec_valid_d  = (count_d != '0);
    dec_pc_d     = '0;
    dec_instr1_d = '0;
    dec_instr2_d = '0;
    if (dec_valid_d) begin
      dec_pc_d     = 32'(pc_mem_d[rd_ptr_d]);
      dec_instr1_d = i1_mem_d[rd_ptr_d];
      dec_instr2_d = i2_mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RST_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      dec_valid_q   <= 1'b0;
      dec_pc_q      <= '0;
      dec_instr1_q  <= '0;
      dec_instr2_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i] <= '0;
        i1_mem_q[i] <= '0;
        i2_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      dec_valid_q   <= dec_valid_d;
      dec_pc_q      <= dec_pc_d;
      dec_instr1_q  <= dec_instr1_d;
      dec_instr2_q  <= dec_instr2_d;
      pc_mem_q      <= pc_mem_d;
      i1_mem_q      <= i1_mem_d;
      i2_mem_q      <= i2_mem_d;
    end
  end

  // A push into a full FIFO means the issue gating has been broken.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (count_q != CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM word n holds n; the word past the end of the
// ROM reads as a poison value that the DUT must replace with a NOP.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr1;
  logic [31:0]       rom_instr2;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              dec_ready;
  logic              dec_valid;
  logic [31:0]       dec_pc;
  logic [31:0]       dec_instr1;
  logic [31:0]       dec_instr2;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_instr1     (rom_instr1),
    .rom_instr2     (rom_instr2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .dec_instr1     (dec_instr1),
    .dec_instr2     (dec_instr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM model, word n = n, out-of-range addr+1 reads as poison.
  always @(posedge clk) begin
    rom_instr1 <= 32'(rom_addr);
    rom_instr2 <= (rom_addr == {ADDR_W{1'b1}}) ? 32'hDEAD_BEEF : 32'(rom_addr) + 32'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input string tag, input logic [31:0] pc,
                            input logic [31:0] i1, input logic [31:0] i2);
    check({tag, ".valid"}, 32'(dec_valid), 32'd1);
    check({tag, ".pc"}, dec_pc, pc);
    check({tag, ".i1"}, dec_instr1, i1);
    check({tag, ".i2"}, dec_instr2, i2);
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, 32'(dec_valid), 32'd0);
    check({tag, ".pc"}, dec_pc, 32'd0);
    check({tag, ".i1"}, dec_instr1, 32'd0);
    check({tag, ".i2"}, dec_instr2, 32'd0);
  endtask

  task automatic do_reset(input logic ready);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = ready;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  initial begin
    // 1: reset state, then back-to-back pairs from pc 0
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
    #1;
    check_empty("s1.in_reset");
    check("s1.rom_addr_rst", 32'(rom_addr), 32'd0);
    do_reset(1'b1);
    step();
    check("s1.edge1.valid", 32'(dec_valid), 32'd0);
    step();
    check_pair("s1.p0", 32'd0, 32'd0, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_pair($sformatf("s1.p%0d", k), 32'(8 * k), 32'(2 * k), 32'(2 * k + 1));
    end

    // 2: decode stalled from reset fills exactly four pairs, then drains in order
    do_reset(1'b0);
    repeat (6) step();
    check_pair("s2.head", 32'd0, 32'd0, 32'd1);
    check("s2.rom_addr", 32'(rom_addr), 32'd8);
    step();
    check_pair("s2.hold", 32'd0, 32'd0, 32'd1);
    check("s2.rom_addr_hold", 32'(rom_addr), 32'd8);
    dec_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_pair($sformatf("s2.drain%0d", k), 32'(8 * k), 32'(2 * k), 32'(2 * k + 1));
    end

    // 3: redirect with three pairs buffered and one in flight
    do_reset(1'b0);
    repeat (4) step();
    check_pair("s3.pre", 32'd0, 32'd0, 32'd1);
    dec_ready = 1'b1;
    redirect(32'h104);
    check_empty("s3.r0");
    step();
    check("s3.r1.valid", 32'(dec_valid), 32'd0);
    step();
    check_pair("s3.p0", 32'h104, 32'd65, 32'd66);
    step();
    check_pair("s3.p1", 32'h10C, 32'd67, 32'd68);
    step();
    check_pair("s3.p2", 32'h114, 32'd69, 32'd70);

    // 4: misaligned redirect is aligned down
    redirect(32'h103);
    check("s4.r0.valid", 32'(dec_valid), 32'd0);
    step();
    check("s4.r1.valid", 32'(dec_valid), 32'd0);
    step();
    check_pair("s4.p0", 32'h100, 32'd64, 32'd65);
    step();
    check_pair("s4.p1", 32'h108, 32'd66, 32'd67);

    // 5: last ROM word pairs with a NOP; 0xFFC+8 wraps modulo 4 KiB to 0x004
    redirect(32'hFFC);
    step();
    step();
    check_pair("s5.end", 32'hFFC, 32'd1023, 32'h0000_0013);
    step();
    check_pair("s5.wrap", 32'h004, 32'd1, 32'd2);

    // 6: async reset with a full FIFO, then identical restart to scenario 1
    dec_ready = 1'b0;
    repeat (6) step();
    check("s6.full.valid", 32'(dec_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_empty("s6.async");
    check("s6.rom_addr", 32'(rom_addr), 32'd0);
    step();
    check_empty("s6.held");
    rst = 1'b0;
    dec_ready = 1'b1;
    step();
    check("s6.edge1.valid", 32'(dec_valid), 32'd0);
    for (int k = 0; k <= 3; k++) begin
      step();
      check_pair($sformatf("s6.p%0d", k), 32'(8 * k), 32'(2 * k), 32'(2 * k + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
